// File: rtl/sar_search.sv
// Successive-approximation search engine that locates an unknown value by
// driving probes into an external magnitude comparator and reading back gt/lt/eq.
module sar_search #(
  parameter int WORD = 16,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            cmp_gt,
  input  logic            cmp_lt,
  input  logic            cmp_eq,
  output logic [WORD-1:0] probe,
  output logic            probe_valid,
  output logic            busy,
  output logic            done,
  output logic            found,
  output logic            err,
  output logic [WORD-1:0] result,
  output logic [CNTW-1:0] probes
);

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    DONE
  } state_t;

  localparam logic [WORD-1:0] MAX_VAL = '1;

  state_t          state;
  logic [WORD-1:0] low;
  logic [WORD-1:0] high;

  logic            flags_legal;
  logic [WORD-1:0] new_low;
  logic [WORD-1:0] new_high;

  // Midpoint in one extra bit so lo + span/2 can never wrap.
  function automatic logic [WORD-1:0] midpoint(input logic [WORD-1:0] lo,
                                               input logic [WORD-1:0] hi);
    logic [WORD:0] sum;
    sum = {1'b0, lo} + (({1'b0, hi} - {1'b0, lo}) >> 1);
    return sum[WORD-1:0];
  endfunction

  // new_low/new_high are only consumed when probe < high / probe > low,
  // so neither increment nor decrement can wrap where it matters.
  always_comb begin
    flags_legal = $onehot({cmp_gt, cmp_lt, cmp_eq});
    new_low     = probe + 1'b1;
    new_high    = probe - 1'b1;
  end

  // NOTE: every register in this block uses <= so all updates within one
  // edge see the pre-edge values of probe, low, high and probes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      low         <= '0;
      high        <= '0;
      probe       <= '0;
      probe_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      err         <= 1'b0;
      result      <= '0;
      probes      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            low         <= '0;
            high        <= MAX_VAL;
            probe       <= MAX_VAL >> 1;
            probes      <= CNTW'(1);
            found       <= 1'b0;
            err         <= 1'b0;
            result      <= '0;
            probe_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= PROBE;
          end
        end

        PROBE: begin
          if (!flags_legal) begin
            err         <= 1'b1;
            found       <= 1'b0;
            probe_valid <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else if (cmp_eq) begin
            found       <= 1'b1;
            result      <= probe;
            probe_valid <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else if (cmp_gt) begin
            if (probe == high) begin
              probe_valid <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              low    <= new_low;
              probe  <= midpoint(new_low, high);
              probes <= probes + CNTW'(1);
            end
          end else begin
            // Only cmp_lt can be set here; probe == low also covers probe == 0.
            if (probe == low) begin
              probe_valid <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              high   <= new_high;
              probe  <= midpoint(low, new_high);
              probes <= probes + CNTW'(1);
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          probe_valid <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
